// File: rtl/duty_slew_ctrl_pkg.sv
// duty_pkg: shared widths, slew FSM state type and the duty saturation helper
// used by the duty_slew_ctrl slice.
package duty_pkg;

    localparam int DUTY_W = 11;   // PWM stage duty width
    localparam int SPD_W  = 12;   // signed speed command / level width

    typedef enum logic {
        RUN   = 1'b0,
        DWELL = 1'b1
    } slew_state_t;

    // |v| saturated into DUTY_W bits. Only -2048 has a magnitude that does not
    // fit, so it maps to full scale.
    function automatic logic [DUTY_W-1:0] sat_mag(input logic signed [SPD_W-1:0] v);
        logic [SPD_W-1:0] m;
        m = v;
        if (v[SPD_W-1]) begin
            m = ~m + SPD_W'(1);
        end
        return m[SPD_W-1] ? {DUTY_W{1'b1}} : m[DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/duty_slew_ctrl_if.sv
// duty_slew_ctrl_if: command in / duty out bundle between a speed command
// source and the duty slew controller.
//   cmd_spd  signed target speed        (master -> slave)
//   cmd_vld  1-cycle capture strobe     (master -> slave)
//   duty     duty magnitude to PWM      (slave -> master)
//   dir      1 = forward, 0 = reverse   (slave -> master)
//   busy     ramping or dwelling        (slave -> master)
interface duty_slew_ctrl_if;
    import duty_pkg::*;

    logic signed [SPD_W-1:0]  cmd_spd;
    logic                     cmd_vld;
    logic        [DUTY_W-1:0] duty;
    logic                     dir;
    logic                     busy;

    modport master (output cmd_spd, cmd_vld, input  duty, dir, busy);
    modport slave  (input  cmd_spd, cmd_vld, output duty, dir, busy);

endinterface

// File: rtl/duty_slew_ctrl_frame_timer.sv
// duty_frame_timer: free-running FRAME_BITS counter that mirrors the PWM
// stage counter. frame_tick_o is high during the last count of each frame, so
// registers enabled by it update on the same edge the PWM counter wraps.
//   clk          clock
//   rst_n        asynchronous active-low reset (counter restarts at 0)
//   frame_tick_o combinational, cnt == all ones
module duty_frame_timer #(
    parameter int FRAME_BITS = 11
) (
    input  logic clk,
    input  logic rst_n,
    output logic frame_tick_o
);

    logic [FRAME_BITS-1:0] cnt_q, cnt_d;

    assign cnt_d        = cnt_q + FRAME_BITS'(1);
    assign frame_tick_o = &cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/duty_slew_ctrl.sv
// duty_slew_ctrl: converts a signed speed command into a slew-limited duty
// magnitude plus direction for the PWM stage. Outputs change only on frame
// ticks; a sign reversal ramps to zero, holds DWELL_FRAMES frames, then flips
// direction and ramps out.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         duty_slew_ctrl_if.slave: cmd_spd/cmd_vld in, duty/dir/busy out
//   estop       (only when DUTY_ESTOP_EN is defined) forces zero duty and a
//               fresh dwell immediately, target cleared, commands ignored
// Optional feature macro: DUTY_ESTOP_EN.
module duty_slew_ctrl
    import duty_pkg::*;
#(
    parameter int STEP         = 16,
    parameter int DWELL_FRAMES = 4,
    parameter int FRAME_BITS   = 11
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef DUTY_ESTOP_EN
    input  logic             estop,
`endif
    duty_slew_ctrl_if.slave  bus
);

    localparam int DW = (DWELL_FRAMES < 1) ? 1 : $clog2(DWELL_FRAMES + 1);
    localparam logic [SPD_W:0]          STEP_MAG = (SPD_W+1)'(STEP);
    localparam logic signed [SPD_W-1:0] STEP_LVL = SPD_W'(STEP);

    logic frame_tick;

    duty_frame_timer #(.FRAME_BITS(FRAME_BITS)) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick_o (frame_tick)
    );

    slew_state_t              state_q, state_d;
    logic signed [SPD_W-1:0]  target_q, target_d;
    logic signed [SPD_W-1:0]  level_q, level_d;
    logic        [DW-1:0]     dwell_q, dwell_d;
    logic                     dir_q, dir_d;
    logic                     busy_q, busy_d;
    logic        [DUTY_W-1:0] duty_q, duty_d;

    // Decisions on a tick use the target held before that edge, so a command
    // strobed on the tick edge itself takes effect one frame later.
    logic                     tgt_pos, tgt_neg, same_side;
    logic signed [SPD_W:0]    diff;
    logic        [SPD_W:0]    diff_mag;
    logic        [SPD_W:0]    lvl_mag;

    always_comb begin
        tgt_neg   = target_q[SPD_W-1];
        tgt_pos   = !target_q[SPD_W-1] && (target_q != '0);
        same_side = (target_q == '0) || (tgt_pos && dir_q) || (tgt_neg && !dir_q);
        // 13-bit difference: target and level span the full 12-bit range.
        diff      = $signed({target_q[SPD_W-1], target_q}) - $signed({level_q[SPD_W-1], level_q});
        diff_mag  = diff[SPD_W] ? (~diff + (SPD_W+1)'(1)) : diff;
        lvl_mag   = level_q[SPD_W-1] ? (~{level_q[SPD_W-1], level_q} + (SPD_W+1)'(1))
                                     : {1'b0, level_q};
    end

    always_comb begin
        state_d  = state_q;
        target_d = bus.cmd_vld ? bus.cmd_spd : target_q;
        level_d  = level_q;
        dwell_d  = dwell_q;
        dir_d    = dir_q;
        busy_d   = busy_q;
        duty_d   = duty_q;

        if (frame_tick) begin
            case (state_q)
                RUN: begin
                    if (same_side) begin
                        if (diff_mag <= STEP_MAG)  level_d = target_q;
                        else if (diff[SPD_W])      level_d = level_q - STEP_LVL;
                        else                       level_d = level_q + STEP_LVL;
                    end else begin
                        // Reversal: approach zero without crossing it; the tick
                        // that lands on zero starts the dwell.
                        if (lvl_mag <= STEP_MAG)   level_d = '0;
                        else if (level_q[SPD_W-1]) level_d = level_q + STEP_LVL;
                        else                       level_d = level_q - STEP_LVL;
                        if (level_d == '0) begin
                            state_d = DWELL;
                            dwell_d = DW'(DWELL_FRAMES);
                        end
                    end
                end
                DWELL: begin
                    // Runs to completion regardless of target changes; the
                    // direction is chosen from whatever target is current now.
                    level_d = '0;
                    dwell_d = dwell_q - DW'(1);
                    if (dwell_q == DW'(1)) begin
                        state_d = RUN;
                        if (tgt_pos)      dir_d = 1'b1;
                        else if (tgt_neg) dir_d = 1'b0;
                    end
                end
                default: state_d = RUN;
            endcase
            busy_d = (state_d == DWELL) || (level_d != target_q);
            duty_d = (state_d == DWELL) ? '0 : sat_mag(level_d);
        end

`ifdef DUTY_ESTOP_EN
        // Stop wins over both commands and frame ticks, every edge it is high.
        if (estop) begin
            state_d  = DWELL;
            target_d = '0;
            level_d  = '0;
            dwell_d  = DW'(DWELL_FRAMES);
            busy_d   = 1'b1;
            duty_d   = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            target_q <= '0;
            level_q  <= '0;
            dwell_q  <= '0;
            dir_q    <= 1'b1;
            busy_q   <= 1'b0;
            duty_q   <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            level_q  <= level_d;
            dwell_q  <= dwell_d;
            dir_q    <= dir_d;
            busy_q   <= busy_d;
            duty_q   <= duty_d;
        end
    end

    assign bus.duty = duty_q;
    assign bus.dir  = dir_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_duty_slew_ctrl.sv
// tb_duty_slew_ctrl: scoreboard bench. Each scenario pushes the expected
// {duty, dir, busy} per frame tick; every tick edge pops and compares.
// Frame shortened to 16 clocks (FRAME_BITS=4) to keep long ramps cheap.
module tb_duty_slew_ctrl;
    import duty_pkg::*;

    localparam int FB = 4;
    localparam int FR = 1 << FB;

    typedef struct packed {
        logic [DUTY_W-1:0] duty;
        logic              dir;
        logic              busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef DUTY_ESTOP_EN
    logic estop = 1'b0;
`endif

    duty_slew_ctrl_if bus ();

    duty_slew_ctrl #(.STEP(16), .DWELL_FRAMES(4), .FRAME_BITS(FB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef DUTY_ESTOP_EN
        .estop (estop),
`endif
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   fe     = 0;  // edges since last tick
    int   ticks  = 0;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_chk++;
        if (obs != exp_v) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d @%0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic push(input int d, input bit dr, input bit b);
        exp_t e;
        e.duty = DUTY_W'(d);
        e.dir  = dr;
        e.busy = b;
        sb_q.push_back(e);
    endtask

    task automatic on_tick();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk($sformatf("t%0d_sb_underrun", ticks), sb_q.size(), 1);
        end else begin
            e = sb_q.pop_front();
            chk($sformatf("t%0d_duty", ticks), int'(bus.duty), int'(e.duty));
            chk($sformatf("t%0d_dir",  ticks), int'(bus.dir),  int'(e.dir));
            chk($sformatf("t%0d_busy", ticks), int'(bus.busy), int'(e.busy));
        end
    endtask

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            fe++;
            if (fe == FR) begin
                fe = 0;
                ticks++;
                on_tick();
            end
        end
    endtask

    task automatic run_ticks(input int n);
        int t0;
        t0 = ticks;
        while (ticks < t0 + n) adv(1);
    endtask

    task automatic send_cmd(input int v);
        bus.cmd_spd = SPD_W'(v);
        bus.cmd_vld = 1'b1;
        adv(1);
        bus.cmd_vld = 1'b0;
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_duty"}, int'(bus.duty), 0);
        chk({tag, "_dir"},  int'(bus.dir),  1);
        chk({tag, "_busy"}, int'(bus.busy), 0);
    endtask

    task automatic do_reset(input string tag);
        chk({tag, "_sb_left"}, sb_q.size(), 0);
        sb_q.delete();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_rst(tag);
        @(negedge clk);
        rst_n = 1'b1;
        fe = 0;
    endtask

    initial begin
        bus.cmd_spd = '0;
        bus.cmd_vld = 1'b0;

        // Idle after reset: nothing moves.
        do_reset("r1");
        for (int i = 0; i < 3; i++) push(0, 1'b1, 1'b0);
        run_ticks(3);

        // Ramp up to +100.
        send_cmd(100);
        for (int k = 1; k <= 6; k++) push(16 * k, 1'b1, 1'b1);
        push(100, 1'b1, 1'b0);
        run_ticks(7);

        // Reverse to -50: down to zero, dwell, flip, ramp out.
        send_cmd(-50);
        for (int d = 84; d >= 4; d -= 16) push(d, 1'b1, 1'b1);
        push(0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) push(0, 1'b1, 1'b1);
        push(0, 1'b0, 1'b1);
        push(16, 1'b0, 1'b1);
        push(32, 1'b0, 1'b1);
        push(48, 1'b0, 1'b1);
        push(50, 1'b0, 1'b0);
        run_ticks(15);

        // Full reverse scale from zero: dwell first, then saturating magnitude.
        do_reset("r2");
        send_cmd(-2048);
        for (int i = 0; i < 4; i++) push(0, 1'b1, 1'b1);
        push(0, 1'b0, 1'b1);
        for (int k = 1; k <= 128; k++) push((16 * k > 2047) ? 2047 : 16 * k, 1'b0, k < 128);
        run_ticks(133);

        // Command strobed on the tick edge applies one frame later.
        do_reset("r3");
        adv(FR - 1);
        push(0, 1'b1, 1'b0);
        push(16, 1'b1, 1'b1);
        send_cmd(200);
        run_ticks(1);

        // Asynchronous reset mid-ramp, then frame counter restarts.
        do_reset("r4");
        send_cmd(100);
        push(16, 1'b1, 1'b1);
        push(32, 1'b1, 1'b1);
        push(48, 1'b1, 1'b1);
        run_ticks(3);
        adv(5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_rst("async");
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        fe = 0;
        send_cmd(100);
        push(16, 1'b1, 1'b1);
        run_ticks(1);

`ifdef DUTY_ESTOP_EN
        // Emergency stop mid-ramp: immediate zero, command ignored, fresh dwell.
        do_reset("r5");
        send_cmd(100);
        push(16, 1'b1, 1'b1);
        push(32, 1'b1, 1'b1);
        push(48, 1'b1, 1'b1);
        run_ticks(3);
        adv(3);
        estop = 1'b1;
        adv(1);
        chk("estop_duty", int'(bus.duty), 0);
        chk("estop_busy", int'(bus.busy), 1);
        send_cmd(300);
        adv(2);
        estop = 1'b0;
        for (int i = 0; i < 3; i++) push(0, 1'b1, 1'b1);
        push(0, 1'b1, 1'b0);
        push(0, 1'b1, 1'b0);
        run_ticks(5);
`endif

        chk("sb_left_end", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
